mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  N-channel arbiter between the L1 caches (I, D, prefetch, ...) and one downstream line port (L2 cache or pmem).
//  Generalises the two-port I/D arbiter:
//   - parametrised channel count and line/address widths
//   - fixed-priority or round-robin mode
//   - latched, non-preemptible transactions, so a requester dropping its request mid-access cannot corrupt the bus
// PARAMETERS
//  NUM_CH    2    number of requesting channels (2..8); channel 0 = I-cache, 1 = D-cache
//  ADDR_W    16   address width
//  LINE_W    128  cache-line data width
//  BE_W      2    byte-enable width per channel
//  ARB_MODE  1    0 = fixed priority (lowest index wins), 1 = round robin
// PORTS
//  clk           in   1              system clock, all state on rising edge
//  rst_n         in   1              asynchronous, active-low reset
//  ch_read       in   NUM_CH         per-channel line read request (level, held until ch_resp)
//  ch_write      in   NUM_CH         per-channel line write request (level, held until ch_resp)
//  ch_address    in   NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//  ch_wdata      in   NUM_CH*LINE_W  per-channel write line
//  ch_byte_en    in   NUM_CH*BE_W    per-channel byte enable
//  ch_resp       out  NUM_CH         one-hot completion pulse to the granted channel
//  ch_rdata      out  LINE_W         read line, broadcast; valid only with ch_resp
//  mem_read      out  1              downstream read strobe
//  mem_write     out  1              downstream write strobe
//  mem_address   out  ADDR_W         downstream address
//  mem_wdata     out  LINE_W         downstream write line
//  mem_byte_en   out  BE_W           downstream byte enable
//  mem_resp      in   1              downstream completion pulse
//  mem_rdata     in   LINE_W         downstream read line
//  grant_id      out  $clog2(NUM_CH) index of current or last granted channel
//  busy          out  1              high while a transaction is outstanding
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE, rr_ptr=0, grant_id=0
//   - all strobes, ch_resp and busy=0; address/wdata/byte_en=0
//  FSM IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE:
//   - req[i] = ch_read[i] | ch_write[i]; if any req, pick winner w
//       ARB_MODE=0: lowest index with req
//       ARB_MODE=1: first req at or after rr_ptr, wrapping NUM_CH-1 -> 0
//   - latch w, op, address, wdata, byte_en into regs; go to BUSY
//   - rr_ptr <= (w+1) mod NUM_CH (RR mode only)
//  BUSY:
//   - mem_read/mem_write driven from the latched op; addr/data from regs, stable for the whole access
//   - on mem_resp (same cycle, combinational): ch_resp[w]=1, ch_rdata=mem_rdata; go to RELEASE
//  RELEASE:
//   - one dead cycle, all strobes low, so the requester can drop its request
//   - no arbitration this cycle; then IDLE
//  Latency: request first seen in cycle t -> mem strobe in t+1 -> ch_resp in the mem_resp cycle
//   -> next grant decided at earliest mem_resp cycle+2.
//  Boundary conditions:
//   - ch_read and ch_write both high on one channel: treated as write; read is served on a later grant
//   - requester deasserts during BUSY: transaction still completes and ch_resp still pulses
//   - requests arriving during BUSY/RELEASE: held off, never lost
//   - RR fairness: any continuously requesting channel is granted within NUM_CH transactions
//   - mem_resp in IDLE/RELEASE is ignored, no ch_resp
//   - rst_n asserted mid-BUSY: strobes drop immediately (async); the downstream transfer is abandoned
//   - ch_rdata = mem_rdata at all times; consumers must qualify it with ch_resp
// STRUCTURE
//  Shared package lc3b_types:
//   - add arb_state_e {IDLE, BUSY, RELEASE}
//   - reuse lc3b_word and cache_line where LINE_W=128
//  Sub-module rr_pick (combinational):
//   - req vector + pointer -> winner index + valid
//   - rotate, find-first, un-rotate
//   - ARB_MODE=0 ties the pointer to 0
// TESTING
//  Reset:
//   - rst_n=0 with all ch_read high -> mem_read=0, ch_resp=0, busy=0, grant_id=0
//  Single read:
//   - ch_read[1]=1, addr 16'h0040
//   - cycle+1: mem_read=1, mem_address=16'h0040
//   - mem_resp after 3 cycles with rdata X -> ch_resp=2'b10, ch_rdata=X
//  RR contention, NUM_CH=2:
//   - both channels read continuously -> grants alternate 0,1,0,1
//   - each next grant lands exactly 2 cycles after the previous mem_resp
//  Fixed priority, NUM_CH=4, ARB_MODE=0:
//   - ch 2 and ch 3 requesting -> ch 2 served each time, ch 3 starved (expected)
//  Write stability:
//   - ch_write[0], wdata 128'hA5..A5; ch_wdata changed and ch_write dropped mid-BUSY
//   - mem_wdata stays A5..A5 and ch_resp[0] still pulses
//  Async reset mid-BUSY:
//   - rst_n low between edges -> mem_read low within the same cycle
//   - after release, a fresh request is granted from rr_ptr=0

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the L1 -> downstream line-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE -> BUSY -> RELEASE -> IDLE)
//   lc3b_word   : 16-bit machine word (default address width)
//   cache_line  : 128-bit cache line (default line width)
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package mem_port_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  function automatic int unsigned wrap_inc(int unsigned i, int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational rotating priority picker.
//   req : request vector, one bit per channel
//   ptr : highest-priority channel this round (tie to 0 for fixed priority)
//   win : index of the first requester at or after ptr, wrapping
//   vld : at least one request present
// Rotate so ptr lands at bit 0, find-first-set, then add ptr back modulo NUM_CH.
module mem_port_arbiter_rr_pick #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [ID_W-1:0]   win,
  output logic              vld
);

  localparam logic [ID_W:0] NCH = NUM_CH[ID_W:0];

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [ID_W-1:0]     off;
  logic [ID_W:0]       sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: NUM_CH];
    off = '0;
    vld = 1'b0;
    // descending scan so the lowest rotated index is the one that sticks
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = ID_W'(i);
        vld = 1'b1;
      end
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= NCH) sum = sum - NCH;
    win = sum[ID_W-1:0];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter between L1 caches and one downstream line port.
// A grant latches op/address/data/byte-enable, so the downstream access stays
// stable even if the requester changes or drops its inputs mid-access.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ch_read/ch_write            per-channel level requests, held until ch_resp
//   ch_address/ch_wdata/ch_byte_en  per-channel request payload, channel i in slice i
//   ch_resp                     one-hot completion pulse to the granted channel
//   ch_rdata                    read line, broadcast (qualify with ch_resp)
//   mem_read/mem_write/mem_address/mem_wdata/mem_byte_en  downstream request
//   mem_resp/mem_rdata          downstream completion and read line
//   grant_id                    current or last granted channel
//   busy                        downstream access outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int BE_W     = 2,
  parameter int ARB_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  input  logic [NUM_CH*BE_W-1:0]     ch_byte_en,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [LINE_W-1:0]          mem_wdata,
  output logic [BE_W-1:0]            mem_byte_en,
  input  logic                       mem_resp,
  input  logic [LINE_W-1:0]          mem_rdata,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_CH);

  arb_state_e state, state_nxt;

  logic [NUM_CH-1:0]             req;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_CH-1:0][LINE_W-1:0] wdata_a;
  logic [NUM_CH-1:0][BE_W-1:0]   be_a;

  logic [ID_W-1:0]   rr_ptr, pick_ptr, win, win_inc;
  logic              win_vld;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              grant;

  assign addr_a  = ch_address;
  assign wdata_a = ch_wdata;
  assign be_a    = ch_byte_en;
  assign req     = ch_read | ch_write;

  // fixed priority is round robin with the pointer pinned at channel 0
  assign pick_ptr = (ARB_MODE == 1) ? rr_ptr : '0;

  mem_port_arbiter_rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (win),
    .vld (win_vld)
  );

  assign win_inc = (win == ID_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
  assign grant   = (state == IDLE) && win_vld;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld)  state_nxt = BUSY;
      BUSY:    if (mem_resp) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant latch: write wins when a channel raises both read and write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else if (grant) begin
      grant_id <= win;
      op_wr    <= ch_write[win];
      addr_q   <= addr_a[win];
      wdata_q  <= wdata_a[win];
      be_q     <= be_a[win];
      if (ARB_MODE == 1) rr_ptr <= win_inc;
    end
  end

  // outputs
  always_comb begin
    mem_read    = (state == BUSY) && !op_wr;
    mem_write   = (state == BUSY) &&  op_wr;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
    mem_byte_en = be_q;
    busy        = (state == BUSY);
    ch_rdata    = mem_rdata;
    ch_resp     = '0;
    if ((state == BUSY) && mem_resp) ch_resp[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (4-ch round robin, 4-ch fixed priority) share one set
// of request/memory inputs and run in lockstep; each is checked against a
// transaction-level model of who should win and what should appear downstream.
module tb_mem_port_arbiter;

  localparam int NC = 4, AW = 16, LW = 128, BW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0]         ch_read, ch_write;
  logic [NC-1:0][AW-1:0] a_tb;
  logic [NC-1:0][LW-1:0] wd_tb;
  logic [NC-1:0][BW-1:0] be_tb;
  logic                  mem_resp;
  logic [LW-1:0]         mem_rdata;

  logic [NC-1:0] r_resp, f_resp;
  logic [LW-1:0] r_rdata, f_rdata, r_wdata, f_wdata;
  logic          r_rd, r_wr, f_rd, f_wr, r_busy, f_busy;
  logic [AW-1:0] r_addr, f_addr;
  logic [BW-1:0] r_be, f_be;
  logic [1:0]    r_gid, f_gid;

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .LINE_W(LW), .BE_W(BW), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(a_tb), .ch_wdata(wd_tb), .ch_byte_en(be_tb),
    .ch_resp(r_resp), .ch_rdata(r_rdata), .mem_read(r_rd), .mem_write(r_wr),
    .mem_address(r_addr), .mem_wdata(r_wdata), .mem_byte_en(r_be),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .grant_id(r_gid), .busy(r_busy)
  );

  mem_port_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .LINE_W(LW), .BE_W(BW), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(a_tb), .ch_wdata(wd_tb), .ch_byte_en(be_tb),
    .ch_resp(f_resp), .ch_rdata(f_rdata), .mem_read(f_rd), .mem_write(f_wr),
    .mem_address(f_addr), .mem_wdata(f_wdata), .mem_byte_en(f_be),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .grant_id(f_gid), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fp_model(logic [NC-1:0] r);
    for (int i = 0; i < NC; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int rr_model(logic [NC-1:0] r, int p);
    for (int k = 0; k < NC; k++) if (r[(p + k) % NC]) return (p + k) % NC;
    return 0;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction starting from an IDLE cycle. keep: requests stay up
  // through RELEASE; disturb: payload scrambled and requests dropped mid-access.
  task automatic do_txn(input logic [NC-1:0] rd, input logic [NC-1:0] wr, input int lat,
                        input bit keep, input bit disturb, input string tag);
    logic [NC-1:0] req;
    int            fw, rw;
    logic          fwr, rwr;
    logic [AW-1:0] fa, ra;
    logic [LW-1:0] fd, rdd, rdat;
    logic [BW-1:0] fb, rb;
    logic [NC-1:0] foh, roh;
    req = rd | wr;
    ch_read = rd;
    ch_write = wr;
    fw = fp_model(req);
    rw = rr_model(req, rr_m);
    rr_m = (rw + 1) % NC;
    fwr = wr[fw]; rwr = wr[rw];
    fa = a_tb[fw]; ra = a_tb[rw];
    fd = wd_tb[fw]; rdd = wd_tb[rw];
    fb = be_tb[fw]; rb = be_tb[rw];
    foh = 4'b0001 << fw; roh = 4'b0001 << rw;
    #1;
    chk({tag, " idle strobes rr"}, {r_rd, r_wr, r_busy}, 3'b000);
    chk({tag, " idle strobes fp"}, {f_rd, f_wr, f_busy}, 3'b000);
    @(negedge clk); #1;
    chk({tag, " grant rr"}, r_gid, rw[1:0]);
    chk({tag, " grant fp"}, f_gid, fw[1:0]);
    chk({tag, " strobes rr"}, {r_rd, r_wr, r_busy}, {!rwr, rwr, 1'b1});
    chk({tag, " strobes fp"}, {f_rd, f_wr, f_busy}, {!fwr, fwr, 1'b1});
    chk({tag, " addr rr"}, r_addr, ra);
    chk({tag, " addr fp"}, f_addr, fa);
    chk({tag, " be rr"}, r_be, rb);
    chk({tag, " be fp"}, f_be, fb);
    chk({tag, " early resp"}, {r_resp, f_resp}, 8'h00);
    if (disturb) begin
      for (int i = 0; i < NC; i++) begin
        a_tb[i] = AW'($urandom);
        wd_tb[i] = rnd_line();
        be_tb[i] = BW'($urandom);
      end
      ch_read = '0;
      ch_write = '0;
    end
    repeat (lat - 1) @(negedge clk);
    rdat = rnd_line();
    mem_rdata = rdat;
    mem_resp = 1'b1;
    #1;
    chk({tag, " resp rr"}, r_resp, roh);
    chk({tag, " resp fp"}, f_resp, foh);
    chk({tag, " rdata rr"}, r_rdata, rdat);
    chk({tag, " rdata fp"}, f_rdata, rdat);
    chk({tag, " held rr"}, {r_rd, r_wr, r_addr, r_be}, {!rwr, rwr, ra, rb});
    chk({tag, " held fp"}, {f_rd, f_wr, f_addr, f_be}, {!fwr, fwr, fa, fb});
    chk({tag, " wdata rr"}, r_wdata, rdd);
    chk({tag, " wdata fp"}, f_wdata, fd);
    // mem_resp left high into RELEASE: must be ignored there
    @(negedge clk); #1;
    chk({tag, " release resp"}, {r_resp, f_resp}, 8'h00);
    chk({tag, " release strobes"}, {r_rd, r_wr, f_rd, f_wr}, 4'b0000);
    mem_resp = 1'b0;
    if (!keep) begin
      ch_read = '0;
      ch_write = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [NC-1:0] rd, wr;
    ch_read = '1;
    ch_write = '0;
    a_tb = '0;
    wd_tb = '0;
    be_tb = '0;
    mem_resp = 1'b0;
    mem_rdata = '0;

    // reset with every channel requesting
    repeat (2) @(negedge clk);
    #1;
    chk("reset strobes", {r_rd, r_wr, f_rd, f_wr}, 4'b0000);
    chk("reset resp", {r_resp, f_resp}, 8'h00);
    chk("reset busy", {r_busy, f_busy}, 2'b00);
    chk("reset gid", {r_gid, f_gid}, 4'h0);
    chk("reset addr", {r_addr, f_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ch_read = '0;
    @(negedge clk);
    mem_resp = 1'b1;   // stray completion while IDLE
    #1;
    chk("idle stray resp", {r_resp, f_resp}, 8'h00);
    mem_resp = 1'b0;
    @(negedge clk);

    // single read on channel 1
    a_tb[1] = 16'h0040;
    do_txn(4'b0010, 4'b0000, 3, 0, 0, "single");

    // continuous contention on 0 and 1
    for (int i = 0; i < 4; i++) do_txn(4'b0011, 4'b0000, 2, 1, 0, "contend");

    // 2 and 3 contending: fixed priority keeps serving 2
    for (int i = 0; i < 3; i++) do_txn(4'b1100, 4'b0000, 1, 1, 0, "prio");

    // write, payload scrambled and request dropped mid-access
    wd_tb[0] = {16{8'hA5}};
    a_tb[0] = 16'h1230;
    be_tb[0] = 2'b11;
    do_txn(4'b0000, 4'b0001, 4, 0, 1, "wr_stable");

    // read and write together on one channel: write first, read later
    do_txn(4'b0100, 4'b0100, 2, 1, 0, "rw_both");
    do_txn(4'b0100, 4'b0000, 2, 0, 0, "rw_read");

    // async reset mid-access
    ch_read = 4'b0010;
    @(negedge clk); #1;
    chk("pre-reset busy", {r_rd, f_rd}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async strobes", {r_rd, r_wr, f_rd, f_wr}, 4'b0000);
    chk("async busy", {r_busy, f_busy}, 2'b00);
    chk("async gid", {r_gid, f_gid}, 4'h0);
    ch_read = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    @(negedge clk);
    do_txn(4'b1001, 4'b0000, 2, 0, 0, "post_reset");

    // random traffic
    for (int n = 0; n < 40; n++) begin
      rd = NC'($urandom);
      wr = NC'($urandom) & NC'($urandom);
      if ((rd | wr) == '0) rd = NC'(1) << $urandom_range(0, NC - 1);
      for (int i = 0; i < NC; i++) begin
        a_tb[i] = AW'($urandom);
        wd_tb[i] = rnd_line();
        be_tb[i] = BW'($urandom);
      end
      do_txn(rd, wr, $urandom_range(1, 4), 1'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
